// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared state encodings, RV32I opcodes and datapath mux codes
//               for the multicycle RV32I control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // Controller states; encoding 15 is unused and recovers to S_IF
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_BR      = 4'd9,
    S_PC_INC  = 4'd10,
    S_JALR_EX = 4'd11,
    S_JUMP_WB = 4'd12,
    S_ECALL   = 4'd13,
    S_HALT    = 4'd14
  } state_e;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // ALU operand A select
  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_RS1 = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_ALU    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_decode
// Description : Combinational state-to-control decode. All outputs are Moore
//               except ir_write (IF && mem_ready) and the BR pc_write (bcond).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_to_reg,
  output logic       ir_write,
  output logic       pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       is_ecall,
  output logic       is_halted
);

  // Decode the current state into datapath controls; unlisted controls stay 0
  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = M2R_ALUOUT;
    ir_write   = 1'b0;
    pc_source  = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    reg_write  = 1'b0;
    is_ecall   = 1'b0;
    is_halted  = 1'b0;
    case (state)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_ID: begin
        alu_src_b = SRCB_IMM;
      end
      S_EX_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EX_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_EX_ADDR, S_JALR_EX: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_WB_ALU, S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = (state == S_WB_MEM) ? M2R_MDR : M2R_ALUOUT;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
      end
      S_BR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_BRANCH;
        pc_source = 1'b1;
        pc_write  = bcond;
      end
      S_PC_INC: begin
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JUMP_WB: begin
        alu_src_b  = SRCB_FOUR;
        reg_write  = 1'b1;
        mem_to_reg = M2R_ALU;
        pc_source  = 1'b1;
        pc_write   = 1'b1;
      end
      S_ECALL: begin
        is_ecall = 1'b1;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multicycle RV32I control FSM with mem_ready handshake,
//               bounded memory-wait timeout and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W      = 4,   // debug state width, at least 4
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 0    // 0 disables the wait timeout
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               bcond,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               pc_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mem_to_reg,
  output logic               ir_write,
  output logic               pc_source,
  output logic [1:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic               is_ecall,
  output logic               is_halted,
  output logic               mem_timeout,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instr_retired
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  // Counter value seen on the last tolerated stall cycle
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_WAIT_MAX == 0) ? '0 : WAIT_W'(MEM_WAIT_MAX - 1);

  state_e            cur_state;
  state_e            nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timeout_hit;
  logic              retire;

  // A memory-facing state stalls whenever mem_ready is low
  assign waiting = ((cur_state == S_IF) || (cur_state == S_MEM_RD) ||
                    (cur_state == S_MEM_WR)) && !mem_ready;

  // mem_ready in the expiring cycle clears 'waiting', so the access wins
  assign timeout_hit = (MEM_WAIT_MAX != 0) && waiting && (wait_cnt == WAIT_LAST);

  // Instructions retire on leaving their last state; timeouts never retire
  assign retire = (cur_state == S_WB_ALU)  || (cur_state == S_WB_MEM) ||
                  (cur_state == S_PC_INC)  || (cur_state == S_JUMP_WB) ||
                  ((cur_state == S_BR)    && bcond) ||
                  ((cur_state == S_ECALL) && halt_req);

  assign state = STATE_W'(cur_state);

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IF;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; a wait timeout overrides normal sequencing
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IF:      if (mem_ready) nxt_state = S_ID;
      S_ID: begin
        case (opcode)
          OP_RTYPE:          nxt_state = S_EX_R;
          OP_IMM:            nxt_state = S_EX_I;
          OP_LOAD, OP_STORE: nxt_state = S_EX_ADDR;
          OP_BRANCH:         nxt_state = S_BR;
          OP_JAL:            nxt_state = S_JUMP_WB;
          OP_JALR:           nxt_state = S_JALR_EX;
          OP_SYSTEM:         nxt_state = S_ECALL;
          default:           nxt_state = S_PC_INC;
        endcase
      end
      S_EX_R, S_EX_I: nxt_state = S_WB_ALU;
      S_EX_ADDR: nxt_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) nxt_state = S_WB_MEM;
      S_MEM_WR:  if (mem_ready) nxt_state = S_PC_INC;
      S_WB_ALU, S_WB_MEM, S_PC_INC, S_JUMP_WB: nxt_state = S_IF;
      S_BR:      nxt_state = bcond ? S_IF : S_PC_INC;
      S_JALR_EX: nxt_state = S_JUMP_WB;
      S_ECALL:   nxt_state = halt_req ? S_HALT : S_PC_INC;
      S_HALT:    nxt_state = S_HALT;
      default:   nxt_state = S_IF;
    endcase
    if (timeout_hit) nxt_state = S_HALT;
  end

  // Consecutive-stall counter, cleared whenever the state changes
  always_ff @(posedge clk) begin
    if (reset)                              wait_cnt <= '0;
    else if (nxt_state != cur_state)        wait_cnt <= '0;
    else if (waiting && (wait_cnt != '1))   wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset)            mem_timeout <= 1'b0;
    else if (timeout_hit) mem_timeout <= 1'b1;
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset)                                  instr_retired <= '0;
    else if (retire && (instr_retired != '1))   instr_retired <= instr_retired + 1'b1;
  end

  multicycle_ctrl_decode u_decode (
    .state      (cur_state),
    .bcond      (bcond),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .ir_write   (ir_write),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .is_ecall   (is_ecall),
    .is_halted  (is_halted)
  );

endmodule
`default_nettype wire
